spi_slave_regfile: RTL and testbench

- SPI responder for the 40-bit command frames issued by spi_master_top: 8-bit cmd, 16-bit addr, 16-bit data.
- Implements a 16-bit register bank that SPI frames write and read.
- Used as the on-board/bench counterpart of the sensor-side register interface and as a loopback target for the UART->SPI command path.
- Also exposes a local read port and frame status to fabric logic in the clk40M domain.

---
 rtl/spi_slave_regfile.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: SPI mode-0 responder for 40-bit cmd/addr/data frames.
// Frames write and read a 2**ADDR_W x 16 register bank. All SPI inputs are
// oversampled in the clk40M domain. A local read port and per-frame status
// pulses are provided for fabric logic.
module spi_slave_regfile #(
  parameter int         ADDR_W = 4,
  parameter logic [7:0] CMD_WR = 8'h01,
  parameter logic [7:0] CMD_RD = 8'h02
) (
  input  logic              clk40M,
  input  logic              nRst,
  input  logic              spi_clk,
  input  logic              sl,
  input  logic              mosi,
  output logic              miso,
  input  logic [ADDR_W-1:0] loc_addr,
  output logic [15:0]       loc_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic [7:0]        last_cmd,
  output logic [15:0]       last_addr,
  output logic [15:0]       last_data
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_END  = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Synchronizers plus one extra flop each for edge detection
  logic [1:0]  sclk_sync, sl_sync, mosi_sync;
  logic        sclk_d, sl_d;
  logic        sclk_rise, sclk_fall, sl_rise, sl_fall;

  // Frame capture
  logic [5:0]  bit_cnt;
  logic [14:0] rx_shift;
  logic [15:0] rx_next;
  logic [7:0]  cmd_r;
  logic [15:0] addr_r, data_r, rd_word, rd_sel;
  logic [15:0] tx_shift;
  logic        wr_pend;

  // Frame control decoded from state
  logic        in_frame, miso_en, eval_ok, eval_done, eval_err;

  logic [15:0] bank [DEPTH];

  // Address lies inside the bank when all bits above the index are clear.
  function automatic logic addr_in_range(input logic [15:0] a);
    return (a >> ADDR_W) == 16'd0;
  endfunction

  function automatic logic cmd_known(input logic [7:0] c);
    return (c == CMD_WR) || (c == CMD_RD);
  endfunction

  function automatic logic [ADDR_W-1:0] bank_idx(input logic [15:0] a);
    return a[ADDR_W-1:0];
  endfunction

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign sl_rise   = sl_sync[1] & ~sl_d;
  assign sl_fall   = ~sl_sync[1] & sl_d;

  assign rx_next   = {rx_shift, mosi_sync[1]};

  // Read source chosen at the ADDR->DATA boundary from the address just shifted in
  assign rd_sel    = ((cmd_r == CMD_RD) && addr_in_range(rx_next)) ?
                     bank[bank_idx(rx_next)] : 16'h0000;

  // Bring the SPI pins into clk40M and keep the previous sampled level
  always_ff @(posedge clk40M or negedge nRst) begin
    if (!nRst) begin
      sclk_sync <= 2'b00;
      sl_sync   <= 2'b00;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b0;
      sl_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_clk};
      sl_sync   <= {sl_sync[0], sl};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_d    <= sclk_sync[1];
      sl_d      <= sl_sync[1];
    end
  end

  // Frame state register
  always_ff @(posedge clk40M or negedge nRst) begin
    if (!nRst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: advance on bit boundaries, any sl rise ends the frame
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (sl_fall) state_nxt = S_CMD;
      S_CMD: begin
        if (sl_rise)                            state_nxt = S_IDLE;
        else if (sclk_rise && bit_cnt == 6'd7)  state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (sl_rise)                            state_nxt = S_IDLE;
        else if (sclk_rise && bit_cnt == 6'd23) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (sl_rise)                            state_nxt = S_IDLE;
        else if (sclk_rise && bit_cnt == 6'd39) state_nxt = S_END;
      end
      S_END:  if (sl_rise) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State outputs: miso enable and the frame verdict on sl rise
  always_comb begin
    in_frame  = (state != S_IDLE);
    miso_en   = (state == S_DATA) && !sl_sync[1];
    eval_ok   = (bit_cnt == 6'd40) && cmd_known(cmd_r) && addr_in_range(addr_r);
    eval_done = 1'b0;
    eval_err  = 1'b0;
    if (in_frame && sl_rise) begin
      if ((state == S_END) && eval_ok) eval_done = 1'b1;
      else                             eval_err  = 1'b1;
    end
  end

  // Shift in mosi, count bits, latch cmd/addr/data at their last bit
  always_ff @(posedge clk40M or negedge nRst) begin
    if (!nRst) begin
      bit_cnt  <= 6'd0;
      rx_shift <= 15'd0;
      cmd_r    <= 8'h00;
      addr_r   <= 16'h0000;
      data_r   <= 16'h0000;
      rd_word  <= 16'h0000;
      wr_pend  <= 1'b0;
    end else begin
      wr_pend <= 1'b0;
      if (sl_fall) begin
        bit_cnt <= 6'd0;
      end else if (in_frame && sclk_rise) begin
        rx_shift <= rx_next[14:0];
        if (bit_cnt != 6'd41) bit_cnt <= bit_cnt + 6'd1;
        case (bit_cnt)
          6'd7:  cmd_r <= rx_next[7:0];
          6'd23: begin
            addr_r  <= rx_next;
            rd_word <= rd_sel;
          end
          6'd39: begin
            data_r  <= rx_next;
            wr_pend <= (cmd_r == CMD_WR) && addr_in_range(addr_r);
          end
          default: ;
        endcase
      end
    end
  end

  // Load read word at ADDR->DATA; present next bit on miso after each falling edge
  always_ff @(posedge clk40M or negedge nRst) begin
    if (!nRst) begin
      tx_shift <= 16'h0000;
      miso     <= 1'b0;
    end else begin
      if (!miso_en) begin
        miso <= 1'b0;
      end else if (sclk_fall) begin
        miso     <= tx_shift[15];
        tx_shift <= {tx_shift[14:0], 1'b0};
      end
      if ((state == S_ADDR) && sclk_rise && (bit_cnt == 6'd23)) begin
        tx_shift <= rd_sel;
      end
    end
  end

  // Register bank: commit the write one cycle after the 40th bit
  always_ff @(posedge clk40M or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= 16'h0000;
    end else if (wr_pend) begin
      bank[bank_idx(addr_r)] <= data_r;
    end
  end

  // Local read port, one-cycle latency; a same-cycle commit shows up next cycle
  always_ff @(posedge clk40M or negedge nRst) begin
    if (!nRst) begin
      loc_data <= 16'h0000;
    end else begin
      loc_data <= bank[loc_addr];
    end
  end

  // Frame status pulses and record of the last good frame
  always_ff @(posedge clk40M or negedge nRst) begin
    if (!nRst) begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      last_cmd   <= 8'h00;
      last_addr  <= 16'h0000;
      last_data  <= 16'h0000;
    end else begin
      frame_done <= eval_done;
      frame_err  <= eval_err;
      if (eval_done) begin
        last_cmd  <= cmd_r;
        last_addr <= addr_r;
        last_data <= (cmd_r == CMD_RD) ? rd_word : data_r;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb_spi_slave_regfile: drives mode-0 SPI frames at 4 MHz into
// spi_slave_regfile and compares against a frame-level model of the bank.
`timescale 1ns/1ps
module tb_spi_slave_regfile;

  localparam int HALF = 125;

  logic        clk40M = 1'b0;
  logic        nRst = 1'b0;
  logic        spi_clk = 1'b0;
  logic        sl = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [3:0]  loc_addr = 4'd0;
  logic [15:0] loc_data;
  logic        frame_done, frame_err;
  logic [7:0]  last_cmd;
  logic [15:0] last_addr, last_data;

  spi_slave_regfile #(.ADDR_W(4), .CMD_WR(8'h01), .CMD_RD(8'h02)) dut (
    .clk40M(clk40M), .nRst(nRst), .spi_clk(spi_clk), .sl(sl), .mosi(mosi),
    .miso(miso), .loc_addr(loc_addr), .loc_data(loc_data),
    .frame_done(frame_done), .frame_err(frame_err),
    .last_cmd(last_cmd), .last_addr(last_addr), .last_data(last_data)
  );

  always #12.5 clk40M = ~clk40M;

  // Reference model
  logic [15:0] mdl [16];
  logic [7:0]  m_cmd = 8'h00;
  logic [15:0] m_addr = 16'h0, m_data = 16'h0;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse counters
  int done_cnt = 0;
  int err_cnt = 0;
  always @(negedge clk40M) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  // Local-read transition watcher
  bit          watch = 1'b0;
  int          trans = 0;
  logic [15:0] prev_v, before_v, after_v;
  always @(negedge clk40M) begin
    if (watch) begin
      if (loc_data !== prev_v) begin
        trans++;
        before_v = prev_v;
        after_v  = loc_data;
      end
      prev_v = loc_data;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic loc_check(input logic [3:0] a);
    @(negedge clk40M);
    loc_addr = a;
    @(negedge clk40M);
    chk("loc_data", loc_data, mdl[a]);
  endtask

  task automatic bank_check_all();
    for (int k = 0; k < 16; k++) loc_check(k[3:0]);
  endtask

  // One SPI frame of nbits; rst_at >= 0 pulses nRst before that bit
  task automatic spi_frame(input logic [7:0] cmd, input logic [15:0] addr,
                           input logic [15:0] data, input int nbits, input int rst_at);
    logic [39:0] tx, got_vec, exp_vec;
    logic [15:0] rd;
    bit          valid_addr, known, rst_hit, exp_done, exp_err;
    int          d0, e0;
    tx         = {cmd, addr, data};
    valid_addr = (addr < 16);
    known      = (cmd == 8'h01) || (cmd == 8'h02);
    rd         = (cmd == 8'h02 && valid_addr) ? mdl[addr[3:0]] : 16'h0000;
    got_vec    = '0;
    exp_vec    = '0;
    rst_hit    = 1'b0;
    exp_done   = 1'b0;
    exp_err    = 1'b0;
    #($urandom_range(0, 24));
    d0 = done_cnt;
    e0 = err_cnt;
    chk("miso_idle", miso, 1'b0);
    sl = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 40) ? tx[39-i] : 1'($urandom_range(0, 1));
      if (i == rst_at) begin
        @(negedge clk40M);
        nRst = 1'b0;
        #2;
        chk("rst_miso", miso, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_last", {last_cmd, last_addr, last_data}, 40'h0);
        chk("rst_loc", loc_data, 16'h0);
        repeat (3) @(negedge clk40M);
        nRst = 1'b1;
        for (int k = 0; k < 16; k++) mdl[k] = 16'h0;
        m_cmd = 8'h00; m_addr = 16'h0; m_data = 16'h0;
        rst_hit = 1'b1;
      end
      #HALF;
      if (i < 40) begin
        got_vec[39-i] = miso;
        exp_vec[39-i] = (!rst_hit && i >= 24) ? rd[39-i] : 1'b0;
      end
      spi_clk = 1'b1;
      #HALF;
      spi_clk = 1'b0;
    end
    #HALF;
    sl = 1'b1;
    repeat (10) @(posedge clk40M);
    if (!rst_hit) begin
      if (nbits >= 40 && cmd == 8'h01 && valid_addr) mdl[addr[3:0]] = data;
      if (nbits == 40 && known && valid_addr) begin
        exp_done = 1'b1;
        m_cmd  = cmd;
        m_addr = addr;
        m_data = (cmd == 8'h02) ? rd : data;
      end else begin
        exp_err = 1'b1;
      end
    end
    chk("miso_bits", got_vec, exp_vec);
    chk("done_pulses", done_cnt - d0, exp_done);
    chk("err_pulses", err_cnt - e0, exp_err);
    chk("last_cmd", last_cmd, m_cmd);
    chk("last_addr", last_addr, m_addr);
    chk("last_data", last_data, m_data);
  endtask

  initial begin
    logic [7:0]  rc;
    logic [15:0] ra;
    int          rn, r;
    for (int k = 0; k < 16; k++) mdl[k] = 16'h0;

    // Reset state
    repeat (4) @(negedge clk40M);
    chk("reset_outs", {miso, frame_done, frame_err}, 3'b000);
    chk("reset_last", {last_cmd, last_addr, last_data}, 40'h0);
    chk("reset_loc", loc_data, 16'h0);
    nRst = 1'b1;
    repeat (4) @(negedge clk40M);
    bank_check_all();

    // Basic write then read-back
    spi_frame(8'h01, 16'h0003, 16'hBEEF, 40, -1);
    loc_check(4'd3);
    spi_frame(8'h02, 16'h0003, 16'h0000, 40, -1);
    loc_check(4'd3);

    // Short, out-of-range, unknown command, long frame
    spi_frame(8'h01, 16'h0005, 16'h1234, 30, -1);
    loc_check(4'd5);
    spi_frame(8'h01, 16'h0010, 16'hAAAA, 40, -1);
    loc_check(4'd0);
    spi_frame(8'h02, 16'h0010, 16'h0000, 40, -1);
    spi_frame(8'h7F, 16'h0002, 16'h5555, 40, -1);
    loc_check(4'd2);
    spi_frame(8'h01, 16'h0006, 16'hCAFE, 41, -1);
    loc_check(4'd6);

    // Sweep all registers
    for (int i = 0; i < 16; i++) spi_frame(8'h01, 16'(i), 16'(16'h1111 * i), 40, -1);
    for (int i = 0; i < 16; i++) spi_frame(8'h02, 16'(i), 16'h0000, 40, -1);
    bank_check_all();

    // Local read colliding with a commit
    @(negedge clk40M);
    loc_addr = 4'd7;
    repeat (2) @(negedge clk40M);
    @(posedge clk40M);
    prev_v = loc_data;
    trans  = 0;
    watch  = 1'b1;
    spi_frame(8'h01, 16'h0007, 16'h0707, 40, -1);
    @(posedge clk40M);
    watch = 1'b0;
    chk("coll_trans", trans, 1);
    chk("coll_old", before_v, 16'h7777);
    chk("coll_new", after_v, 16'h0707);

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      r  = $urandom_range(0, 9);
      rc = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom);
      ra = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      rn = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 43) : 40;
      spi_frame(rc, ra, 16'($urandom), rn, -1);
      loc_check(4'($urandom_range(0, 15)));
    end

    // Reset in the middle of a write frame, then recovery
    @(negedge clk40M);
    loc_addr = 4'd15;
    spi_frame(8'h01, 16'h0004, 16'h4444, 40, 20);
    bank_check_all();
    spi_frame(8'h01, 16'h0002, 16'h1357, 40, -1);
    spi_frame(8'h02, 16'h0002, 16'h0000, 40, -1);
    loc_check(4'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
